// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with valid/ready handshake and occupancy count.
// Define IDEX_SKID_EN for a two-entry (main + skid) stage with a registered id_ready.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_inst,
  input  logic [XLEN-1:0]   id_s_op1,
  input  logic [XLEN-1:0]   id_s_op2,
  input  logic [REG_AW-1:0] id_reg_waddr,
  input  logic              id_reg_we,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_inst,
  output logic [XLEN-1:0]   ex_s_op1,
  output logic [XLEN-1:0]   ex_s_op2,
  output logic [REG_AW-1:0] ex_reg_waddr,
  output logic              ex_reg_we,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [XLEN-1:0]   inst;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [REG_AW-1:0] waddr;
    logic              we;
  } payload_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t   state;
  payload_t in_pl, main_q;
  logic     vld_q;
  logic [1:0] occ_q;
  logic     in_fire, out_fire;

  assign in_pl = '{inst: id_inst, op1: id_s_op1, op2: id_s_op2,
                   waddr: id_reg_waddr, we: id_reg_we};

  assign in_fire  = id_valid & id_ready;
  assign out_fire = vld_q & ex_ready;

`ifdef IDEX_SKID_EN
  payload_t skid_q;
  logic     rdy_q;

  // id_ready comes straight from a flop, so ex_ready never reaches ID combinationally.
  assign id_ready = rdy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      vld_q  <= 1'b0;
      occ_q  <= 2'd0;
      rdy_q  <= 1'b0;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      vld_q  <= 1'b0;
      occ_q  <= 2'd0;
      rdy_q  <= 1'b1;
    end else begin
      rdy_q <= 1'b1;
      case (state)
        EMPTY: if (in_fire) begin
          main_q <= in_pl;
          vld_q  <= 1'b1;
          occ_q  <= 2'd1;
          state  <= ONE;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_pl;
          end else if (out_fire) begin
            main_q <= '0;
            vld_q  <= 1'b0;
            occ_q  <= 2'd0;
            state  <= EMPTY;
          end else if (in_fire) begin
            skid_q <= in_pl;
            occ_q  <= 2'd2;
            rdy_q  <= 1'b0;
            state  <= FULL;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q <= skid_q;
            skid_q <= '0;
            occ_q  <= 2'd1;
            state  <= ONE;
          end else begin
            rdy_q <= 1'b0;
          end
        end
        default: begin
          main_q <= '0;
          skid_q <= '0;
          vld_q  <= 1'b0;
          occ_q  <= 2'd0;
          state  <= EMPTY;
        end
      endcase
    end
  end
`else
  logic live_q;

  // live_q keeps id_ready low until the first edge after reset release.
  assign id_ready = live_q & (~vld_q | ex_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= '0;
      vld_q  <= 1'b0;
      occ_q  <= 2'd0;
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (flush) begin
        state  <= EMPTY;
        main_q <= '0;
        vld_q  <= 1'b0;
        occ_q  <= 2'd0;
      end else begin
        case (state)
          EMPTY: if (in_fire) begin
            main_q <= in_pl;
            vld_q  <= 1'b1;
            occ_q  <= 2'd1;
            state  <= ONE;
          end
          ONE: if (out_fire) begin
            if (in_fire) begin
              main_q <= in_pl;
            end else begin
              main_q <= '0;
              vld_q  <= 1'b0;
              occ_q  <= 2'd0;
              state  <= EMPTY;
            end
          end
          default: begin
            main_q <= '0;
            vld_q  <= 1'b0;
            occ_q  <= 2'd0;
            state  <= EMPTY;
          end
        endcase
      end
    end
  end
`endif

  assign ex_valid     = vld_q;
  assign ex_inst      = main_q.inst;
  assign ex_s_op1     = main_q.op1;
  assign ex_s_op2     = main_q.op2;
  assign ex_reg_waddr = main_q.waddr;
  assign ex_reg_we    = main_q.we & vld_q;
  assign occupancy    = occ_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes accepted instructions into a
// queue model, a negedge monitor compares the EX side against the queue head.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [AW-1:0]   wa;
    logic            we;
  } pl_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0, id_valid = 1'b0, ex_ready = 1'b0, id_reg_we = 1'b0;
  logic [XLEN-1:0] id_inst = '0, id_s_op1 = '0, id_s_op2 = '0;
  logic [AW-1:0]   id_reg_waddr = '0;
  logic            id_ready, ex_valid, ex_reg_we;
  logic [XLEN-1:0] ex_inst, ex_s_op1, ex_s_op2;
  logic [AW-1:0]   ex_reg_waddr;
  logic [1:0]      occupancy;

  int  checks = 0;
  int  errors = 0;
  bit  live = 1'b0;
  pl_t q[$];

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_s_op1(id_s_op1), .id_s_op2(id_s_op2),
    .id_reg_waddr(id_reg_waddr), .id_reg_we(id_reg_we),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_inst(ex_inst), .ex_s_op1(ex_s_op1), .ex_s_op2(ex_s_op2),
    .ex_reg_waddr(ex_reg_waddr), .ex_reg_we(ex_reg_we),
    .occupancy(occupancy)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: the model queue holds exactly what the stage should be holding.
  always @(negedge clk) begin
    if (live && rst) begin
      chk("ex_valid", 64'(ex_valid), 64'(q.size() != 0));
      chk("occupancy", 64'(occupancy), 64'(q.size()));
`ifdef IDEX_SKID_EN
      chk("id_ready", 64'(id_ready), 64'(q.size() < 2));
`else
      chk("id_ready", 64'(id_ready), 64'(q.size() == 0 || ex_ready));
      chk("occ_le_1", 64'(occupancy <= 2'd1), 64'd1);
`endif
      if (!ex_valid) begin
        chk("bubble_we", 64'(ex_reg_we), 64'd0);
      end else if (q.size() != 0) begin
        pl_t got;
        got = '{ex_inst, ex_s_op1, ex_s_op2, ex_reg_waddr, ex_reg_we};
        checks++;
        if (got !== q[0]) begin
          errors++;
          $display("FAIL payload: got inst %h op1 %h op2 %h wa %0d we %b expected inst %h op1 %h op2 %h wa %0d we %b",
                   got.inst, got.op1, got.op2, got.wa, got.we,
                   q[0].inst, q[0].op1, q[0].op2, q[0].wa, q[0].we);
        end
      end
      if (ex_valid && ex_ready && !flush && q.size() != 0) void'(q.pop_front());
    end
  end

  // Called just after a posedge; returns just after the next posedge.
  task automatic step(input bit v, input logic [XLEN-1:0] inst, op1, op2,
                      input logic [AW-1:0] wa, input bit we, input bit rdy, input bit fl);
    id_valid = v; id_inst = inst; id_s_op1 = op1; id_s_op2 = op2;
    id_reg_waddr = wa; id_reg_we = we; ex_ready = rdy; flush = fl;
    #7;
    if (live) begin
      if (fl) q.delete();
      else if (id_valid && id_ready) q.push_back('{inst, op1, op2, wa, we});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, '0, '0, '0, '0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_id_ready", 64'(id_ready), 64'd0);
    chk("rst_ex_inst", 64'(ex_inst), 64'd0);
    chk("rst_ex_we", 64'(ex_reg_we), 64'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_id_ready", 64'(id_ready), 64'd1);
    live = 1'b1;

    // Single instruction, one-cycle latency
    step(1'b1, 32'h00500093, 32'd0, 32'd5, 5'd1, 1'b1, 1'b1, 1'b0);
    chk("lat_valid", 64'(ex_valid), 64'd1);
    chk("lat_inst", 64'(ex_inst), 64'h00500093);
    chk("lat_op1", 64'(ex_s_op1), 64'd0);
    chk("lat_op2", 64'(ex_s_op2), 64'd5);
    chk("lat_waddr", 64'(ex_reg_waddr), 64'd1);
    chk("lat_we", 64'(ex_reg_we), 64'd1);
    chk("lat_occ", 64'(occupancy), 64'd1);
    idle(1'b1);

    // Backpressure: A then B with ex_ready low
    step(1'b1, 32'h11, 32'h1, 32'h2, 5'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h22, 32'h3, 32'h4, 5'd4, 1'b1, 1'b0, 1'b0);
`ifdef IDEX_SKID_EN
    chk("bp_occ", 64'(occupancy), 64'd2);
    chk("bp_id_ready", 64'(id_ready), 64'd0);
`endif
    chk("bp_inst_a", 64'(ex_inst), 64'h11);
    idle(1'b0);
    chk("bp_hold_a", 64'(ex_inst), 64'h11);
    idle(1'b1);
`ifdef IDEX_SKID_EN
    chk("bp_inst_b", 64'(ex_inst), 64'h22);
`else
    chk("bp_empty", 64'(ex_valid), 64'd0);
`endif
    repeat (2) idle(1'b1);

    // Back-to-back stream of 8
    for (int i = 0; i < 8; i++)
      step(1'b1, 32'h100 + 32'(i), $urandom, $urandom, 5'(i), 1'b1, 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // Flush while held, with a simultaneous input
    step(1'b1, 32'hA1, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hA2, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1);
    chk("fl_valid", 64'(ex_valid), 64'd0);
    chk("fl_we", 64'(ex_reg_we), 64'd0);
    chk("fl_inst", 64'(ex_inst), 64'd0);
    chk("fl_occ", 64'(occupancy), 64'd0);
    repeat (3) idle(1'b1);

    // Asynchronous reset pulse between edges while holding
    step(1'b1, 32'hB1, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hB2, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    id_valid = 1'b0;
    #2;
    live = 1'b0;
    q.delete();
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(ex_valid), 64'd0);
    chk("arst_inst", 64'(ex_inst), 64'd0);
    chk("arst_we", 64'(ex_reg_we), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_id_ready", 64'(id_ready), 64'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("arst_rel_ready", 64'(id_ready), 64'd1);
    chk("arst_rel_valid", 64'(ex_valid), 64'd0);
    live = 1'b1;

    // Random handshake traffic with occasional flush
    for (int i = 0; i < 1000; i++)
      step(($urandom % 4) != 0, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
           ($urandom % 3) != 0, ($urandom % 40) == 0);
    repeat (4) idle(1'b1);
    chk("drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
